// File: rtl/hazard_unit_if.sv
// Bundles decode-stage hazard inputs and the forwarding/stall/flush outputs.
// Latency: wires only; no storage.
// Backpressure: none; the hazard unit drives stall/flush, and the pipeline obeys them.
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 16
);
    // Decode-stage instruction info and the execute-stage redirect
    logic [REG_ADDR_W-1:0] rs1_d_i;
    logic [REG_ADDR_W-1:0] rs2_d_i;
    logic [REG_ADDR_W-1:0] rd_d_i;
    logic                  we_reg_file_d_i;
    logic                  is_load_d_i;
    logic                  pc_src_e_i;

    // Hazard responses
    logic [1:0]            forward_a_e_o;
    logic [1:0]            forward_b_e_o;
    logic                  stall_f_o;
    logic                  stall_d_o;
    logic                  flush_d_o;
    logic                  flush_e_o;
    logic [PERF_W-1:0]     stall_cnt_o;
    logic [PERF_W-1:0]     flush_cnt_o;

    // Pipeline control path side: supplies instruction info, consumes hazard controls
    modport master (
        output rs1_d_i, rs2_d_i, rd_d_i, we_reg_file_d_i, is_load_d_i, pc_src_e_i,
        input  forward_a_e_o, forward_b_e_o, stall_f_o, stall_d_o,
        input  flush_d_o, flush_e_o, stall_cnt_o, flush_cnt_o
    );

    // Hazard unit side
    modport slave (
        input  rs1_d_i, rs2_d_i, rd_d_i, we_reg_file_d_i, is_load_d_i, pc_src_e_i,
        output forward_a_e_o, forward_b_e_o, stall_f_o, stall_d_o,
        output flush_d_o, flush_e_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard responder for the 5-stage RV32 pipeline: forwarding, load-use stall, branch flush, perf counters.
// Latency: all hazard outputs are combinational from the current D inputs and the E/M/W shadow registers.
// Backpressure: a load-use match in D stalls F/D and bubbles E for one cycle; a taken branch flushes D and E.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result
    localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result

    // Shadow of the instruction in E
    logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
    logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
    logic [REG_ADDR_W-1:0] rd_e_q,  rd_e_d;
    logic                  we_e_q,  we_e_d;
    logic                  load_e_q, load_e_d;

    // Shadows of the instructions in M and W; only the writer info matters there
    logic [REG_ADDR_W-1:0] rd_m_q, rd_w_q;
    logic                  we_m_q, we_w_q;

    // Saturating event counters
    logic [PERF_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic                  lwstall;
    logic                  flush_e;

    // Forwarding select for one source operand; M wins over W, and x0 is never forwarded
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != '0) begin
            if (we_m && (rs == rd_m)) begin
                sel = FWD_M;
            end else if (we_w && (rs == rd_w)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    // Hazard detection: load-use stall is suppressed by a taken branch, which flushes the same stages anyway
    always_comb begin
        lwstall = 1'b0;
        if (load_e_q && (rd_e_q != '0) &&
            ((rd_e_q == hz.rs1_d_i) || (rd_e_q == hz.rs2_d_i)) &&
            !hz.pc_src_e_i) begin
            lwstall = 1'b1;
        end
        flush_e = lwstall || hz.pc_src_e_i;
    end

    // Drive hazard outputs from registered state and the current D inputs
    always_comb begin
        hz.forward_a_e_o = fwd_sel(rs1_e_q, rd_m_q, we_m_q, rd_w_q, we_w_q);
        hz.forward_b_e_o = fwd_sel(rs2_e_q, rd_m_q, we_m_q, rd_w_q, we_w_q);
        hz.stall_f_o     = lwstall;
        hz.stall_d_o     = lwstall;
        hz.flush_d_o     = hz.pc_src_e_i;
        hz.flush_e_o     = flush_e;
        hz.stall_cnt_o   = stall_cnt_q;
        hz.flush_cnt_o   = flush_cnt_q;
    end

    // Next state of the E shadow (bubble on flush) and of the saturating counters
    always_comb begin
        rs1_e_d     = hz.rs1_d_i;
        rs2_e_d     = hz.rs2_d_i;
        rd_e_d      = hz.rd_d_i;
        we_e_d      = hz.we_reg_file_d_i;
        load_e_d    = hz.is_load_d_i;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush_e) begin
            rs1_e_d  = '0;
            rs2_e_d  = '0;
            rd_e_d   = '0;
            we_e_d   = 1'b0;
            load_e_d = 1'b0;
        end

        if (lwstall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (hz.pc_src_e_i && (flush_cnt_q != {PERF_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    // Advance the E/M/W shadow pipeline and the counters every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e_q     <= '0;
            rs2_e_q     <= '0;
            rd_e_q      <= '0;
            we_e_q      <= 1'b0;
            load_e_q    <= 1'b0;
            rd_m_q      <= '0;
            we_m_q      <= 1'b0;
            rd_w_q      <= '0;
            we_w_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            rs1_e_q     <= rs1_e_d;
            rs2_e_q     <= rs2_e_d;
            rd_e_q      <= rd_e_d;
            we_e_q      <= we_e_d;
            load_e_q    <= load_e_d;
            rd_m_q      <= rd_e_q;
            we_m_q      <= we_e_q;
            rd_w_q      <= rd_m_q;
            we_w_q      <= we_m_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard responder for the 5-stage RV32 core.
- Consumes decode-stage register indices and control bits, plus the taken-branch/jump indication from execute.
- Tracks destination/write-enable/load info through E, M and W in its own pipeline registers.
- Produces the forwarding selects, stall controls and flush controls that the control path and datapath obey. This includes the flush_e that clears the decode->execute control registers.
- Also keeps saturating stall/flush event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, register index width.
- PERF_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- rs1_d_i  input  REG_ADDR_W  source register 1 of instruction in D
- rs2_d_i  input  REG_ADDR_W  source register 2 of instruction in D
- rd_d_i  input  REG_ADDR_W  destination register of instruction in D
- we_reg_file_d_i  input  1  instruction in D writes the register file
- is_load_d_i  input  1  instruction in D is a load (result_src = memory)
- pc_src_e_i  input  1  taken branch/jump resolved in E
- forward_a_e_o  output  2  ALU operand A select in E: 00 regfile, 10 M-stage ALU result, 01 W-stage result
- forward_b_e_o  output  2  same encoding, operand B
- stall_f_o  output  1  hold PC
- stall_d_o  output  1  hold F->D register
- flush_d_o  output  1  clear F->D register
- flush_e_o  output  1  clear D->E registers (feeds control unit flush)
- stall_cnt_o  output  PERF_W  cycles with stall_d_o=1, saturating
- flush_cnt_o  output  PERF_W  cycles with pc_src_e_i=1, saturating

Behaviour:
- Internal D->E register (rs1_e, rs2_e, rd_e, we_e, load_e):
  - Loads from the *_d_i inputs every clk.
  - Loads all-zero when flush_e_o=1.
- E->M register (rd_m, we_m) and M->W register (rd_w, we_w): plain, load every clk.
- rst (async) clears all internal pipeline registers and both counters.
  - Outputs during reset: forward 00, stall 0, flush_d/flush_e equal to pc_src_e_i, counters 0.
- Forwarding (combinational from registered state), operand A uses rs1_e, B uses rs2_e:
  - 10 if rs==rd_m and we_m and rs!=0.
  - else 01 if rs==rd_w and we_w and rs!=0.
  - else 00.
  - M has priority over W when both match.
  - x0 is never forwarded.
- Load-use stall:
  - lwstall = load_e and rd_e!=0 and (rd_e==rs1_d_i or rd_e==rs2_d_i) and !pc_src_e_i.
  - stall_f_o = stall_d_o = lwstall.
  - Exactly one bubble per load-use pair: next cycle load_e=0, so the stall drops.
- Control hazard: flush_d_o = pc_src_e_i.
- flush_e_o = lwstall or pc_src_e_i.
- Simultaneous taken branch and load-use match: flush wins, stall suppressed.
- W->D same-cycle hazard: not handled here. The register file is write-before-read.
- Counters:
  - Increment on the rising edge when their condition holds.
  - Hold at 2^PERF_W-1 (no wrap).
- Latency: all hazard outputs are valid in the same cycle as their inputs, with no extra cycles.

Test Plan:
- Back-to-back ALU ops (add x5,x1,x2 then sub x6,x5,x3) -> when sub is in E, forward_a_e_o=10, no stall.
- Writer two ahead (add x5; nop; or x7,x3,x5) -> forward_b_e_o=01; writers of x5 in both M and W -> 10.
- lw x5 then add x6,x5,x1 -> exactly one cycle with stall_f=stall_d=flush_e=1. The next cycle has forward_a_e_o=01. stall_cnt_o increments by 1.
- Writes to x0 (add x0,...; add x6,x0,x0) -> forward 00, and a load to x0 creates no stall.
- pc_src_e_i=1 for one cycle with a load-use match in D -> flush_d=flush_e=1, stall_f=stall_d=0, flush_cnt_o +1.
- Assert rst mid-stream with a pending forward -> outputs immediately 00/0, counters 0. Force the counter to its maximum (PERF_W=2, 4 stalls) -> it holds at 3.
